alu_op_sequencer: RTL and testbench

Registered command front end for the 8-bit four-function ALU (ADD/SUB/MUL/DIV). It accepts operand/opcode commands over a valid/ready handshake into a small FIFO. It issues one command at a time to the combinational ALU and captures the ALU result with status flags into an output register held under valid/ready. It sits directly upstream of the ALU and owns its a/b/op inputs and f output.

---
 rtl/alu_op_sequencer.sv | 140 ++++++++++++++
 tb/tb_alu_op_sequencer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - command FIFO and issue FSM in front of the 8-bit four-function ALU
// Optional zero/divide-by-zero flags and all-ones DIV/0 override: define ALU_SEQ_FLAGS_EN.
module alu_op_sequencer #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic [1:0]   in_op,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [1:0]   alu_op,
  input  logic [W-1:0] alu_f,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_f,
  output logic         res_zero,
  output logic         res_dz
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_HOLD} state_t;

  state_t        r_state;
  logic [W-1:0]  r_fa  [DEPTH];
  logic [W-1:0]  r_fb  [DEPTH];
  logic [1:0]    r_fop [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic [W-1:0]  r_opa;
  logic [W-1:0]  r_opb;
  logic [1:0]    r_opc;
  logic          r_res_valid;
  logic [W-1:0]  r_res_f;
  logic          r_res_zero;
  logic          r_res_dz;

  logic          w_push;
  logic          w_pop;
  logic          w_empty;
  logic          w_dz;
  logic          w_zero;
  logic [W-1:0]  w_f;

  // in_ready is a pure function of the registered count, never of res_ready
  assign in_ready = (r_count != L_FULL);
  assign w_empty  = (r_count == '0);
  assign w_push   = in_valid && in_ready;
  assign w_pop    = !w_empty && ((r_state == S_IDLE) || ((r_state == S_HOLD) && res_ready));

`ifdef ALU_SEQ_FLAGS_EN
  assign w_dz   = (r_opc == 2'b11) && (r_opb == '0);
  assign w_f    = w_dz ? '1 : alu_f;
  assign w_zero = (w_f == '0);
`else
  assign w_dz   = 1'b0;
  assign w_f    = alu_f;
  assign w_zero = 1'b0;
`endif

  assign alu_a     = r_opa;
  assign alu_b     = r_opb;
  assign alu_op    = r_opc;
  assign res_valid = r_res_valid;
  assign res_f     = r_res_f;
  assign res_zero  = r_res_zero;
  assign res_dz    = r_res_dz;

  // Storage needs no reset: contents are only visible through the reset pointers
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fa[r_wptr]  <= in_a;
      r_fb[r_wptr]  <= in_b;
      r_fop[r_wptr] <= in_op;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_opa       <= '0;
      r_opb       <= '0;
      r_opc       <= 2'b00;
      r_res_valid <= 1'b0;
      r_res_f     <= '0;
      r_res_zero  <= 1'b0;
      r_res_dz    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_opa   <= r_fa[r_rptr];
            r_opb   <= r_fb[r_rptr];
            r_opc   <= r_fop[r_rptr];
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_res_f     <= w_f;
          r_res_zero  <= w_zero;
          r_res_dz    <= w_dz;
          r_res_valid <= 1'b1;
          r_state     <= S_HOLD;
        end
        S_HOLD: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            if (w_pop) begin
              r_opa   <= r_fa[r_rptr];
              r_opb   <= r_fb[r_rptr];
              r_opc   <= r_fop[r_rptr];
              r_state <= S_EXEC;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - directed and randomized self-checking bench for alu_op_sequencer
module tb_alu_op_sequencer;
  localparam int W     = 8;
  localparam int DEPTH = 4;
`ifdef ALU_SEQ_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  logic         clk       = 1'b0;
  logic         rst_n     = 1'b0;
  logic         in_valid  = 1'b0;
  logic [W-1:0] in_a      = '0;
  logic [W-1:0] in_b      = '0;
  logic [1:0]   in_op     = '0;
  logic         res_ready = 1'b0;
  logic         in_ready;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [1:0]   alu_op;
  logic [W-1:0] alu_f;
  logic         res_valid;
  logic [W-1:0] res_f;
  logic         res_zero;
  logic         res_dz;

  int passes = 0;
  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.W(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_f(alu_f),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_f(res_f), .res_zero(res_zero), .res_dz(res_dz)
  );

  // Stand-in for the external ALU; DIV by zero returns operand a
  function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    logic [15:0] p;
    case (op)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    begin p = a * b; return p[7:0]; end
      default: return (b == 8'h00) ? a : a / b;
    endcase
  endfunction

  assign alu_f = alu_model(alu_a, alu_b, alu_op);

  // Expected {dz, zero, f} for a command {a, b, op}
  function automatic logic [9:0] exp_out(input logic [17:0] c);
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] f;
    logic [1:0] op;
    a = c[17:10]; b = c[9:2]; op = c[1:0];
`ifdef ALU_SEQ_FLAGS_EN
    if (op == 2'd3 && b == 8'h00) return {1'b1, 1'b0, 8'hFF};
    f = alu_model(a, b, op);
    return {1'b0, f == 8'h00, f};
`else
    f = alu_model(a, b, op);
    return {2'b00, f};
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end else begin
      passes++;
    end
  endtask

  logic [17:0] mq[$];
  logic [7:0]  done_f[$];
  logic        done_dz[$];
  int          done_t[$];
  logic        prev_hold = 1'b0;
  logic [9:0]  prev_out  = '0;
  logic [9:0]  e;

  // Scoreboard: every cycle a result is presented, it must match the oldest outstanding command
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      mq.delete();
      prev_hold = 1'b0;
    end else begin
      if (res_valid) begin
        chk("result_has_command", mq.size() > 0, 1);
        if (mq.size() > 0) begin
          e = exp_out(mq[0]);
          chk("res_f", res_f, e[7:0]);
          chk("res_zero", res_zero, e[8]);
          chk("res_dz", res_dz, e[9]);
        end
        if (prev_hold) chk("hold_stable", {res_dz, res_zero, res_f}, prev_out);
        if (res_ready) begin
          if (mq.size() > 0) void'(mq.pop_front());
          done_f.push_back(res_f);
          done_dz.push_back(res_dz);
          done_t.push_back(cyc);
        end
      end
      prev_hold = res_valid && !res_ready;
      prev_out  = {res_dz, res_zero, res_f};
      if (in_valid && in_ready) mq.push_back({in_a, in_b, in_op});
    end
  end

  task automatic clear_log();
    done_f.delete(); done_dz.delete(); done_t.delete();
  endtask

  // Called just after a rising edge; returns just after the accepting edge
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    int n;
    in_valid = 1'b1; in_a = a; in_b = b; in_op = op;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    chk("send_accepted", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    res_ready = 1'b1;
    do begin @(negedge clk); #1; n++; end while ((mq.size() != 0 || res_valid) && n < 300);
    chk("drained", mq.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_res_f"}, res_f, 0);
    chk({tag, "_res_zero"}, res_zero, 0);
    chk({tag, "_res_dz"}, res_dz, 0);
    chk({tag, "_alu_abop"}, {alu_a, alu_b, alu_op}, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Model pins
    chk("model_add", exp_out({8'h25, 8'h1A, 2'd0}), {2'b00, 8'h3F});
    chk("model_sub", exp_out({8'h05, 8'h07, 2'd1}), {2'b00, 8'hFE});
    chk("model_mul", exp_out({8'h10, 8'h11, 2'd2}), {2'b00, 8'h10});
    chk("model_div0", exp_out({8'h33, 8'h00, 2'd3}), FLAGS ? {2'b10, 8'hFF} : {2'b00, 8'h33});

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single ADD: latency and one-cycle result
    res_ready = 1'b1;
    send(8'h25, 8'h1A, 2'd0);
    @(negedge clk); chk("add_valid_e0", res_valid, 0);
    @(negedge clk); chk("add_valid_e1", res_valid, 0);
    @(negedge clk); chk("add_valid_e2", res_valid, 1);
    chk("add_res_f", res_f, 8'h3F);
    chk("add_res_zero", res_zero, 0);
    @(negedge clk); chk("add_valid_e3", res_valid, 0);
    @(posedge clk); #1;

    // Back-to-back commands, results 2 cycles apart
    clear_log();
    send(8'h05, 8'h07, 2'd1);
    send(8'h10, 8'h11, 2'd2);
    send(8'hC8, 8'h0A, 2'd3);
    drain();
    chk("b2b_count", done_f.size(), 3);
    chk("b2b_r0", done_f[0], 8'hFE);
    chk("b2b_r1", done_f[1], 8'h10);
    chk("b2b_r2", done_f[2], 8'h14);
    chk("b2b_gap0", done_t[1] - done_t[0], 2);
    chk("b2b_gap1", done_t[2] - done_t[1], 2);

    // Divide by zero
    clear_log();
    send(8'h33, 8'h00, 2'd3);
    drain();
    chk("div0_f", done_f[0], FLAGS ? 8'hFF : 8'h33);
    chk("div0_dz", done_dz[0], FLAGS ? 1 : 0);

    // Back-pressure: 5 commands with the result held
    clear_log();
    res_ready = 1'b0;
    send(8'h01, 8'h02, 2'd0);
    send(8'h80, 8'h03, 2'd1);
    send(8'h0F, 8'h0F, 2'd2);
    send(8'hFF, 8'h10, 2'd3);
    send(8'h00, 8'h00, 2'd0);
    @(negedge clk); chk("full_in_ready", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("held_valid", res_valid, 1);
      chk("held_f", res_f, 8'h03);
    end

    // Pulse res_ready while full with a new command waiting
    @(posedge clk); #1;
    res_ready = 1'b1;
    in_valid = 1'b1; in_a = 8'h07; in_b = 8'h09; in_op = 2'd2;
    @(posedge clk); #1;
    res_ready = 1'b0;
    @(negedge clk); chk("pulse_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk); chk("refull_in_ready", in_ready, 0);
    #1; chk("pulse_one_done", done_f.size(), 1);
    @(posedge clk); #1;
    drain();
    chk("bp_count", done_f.size(), 6);
    chk("bp_last", done_f[5], 8'h3F);
    chk("bp_fourth", done_f[4], 8'h00);

    // Reset during HOLD with 3 queued commands
    res_ready = 1'b0;
    send(8'h11, 8'h22, 2'd0);
    send(8'h33, 8'h11, 2'd1);
    send(8'h04, 8'h04, 2'd2);
    send(8'h40, 8'h02, 2'd3);
    @(negedge clk); chk("pre_reset_valid", res_valid, 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_reset("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    res_ready = 1'b1;
    clear_log();
    repeat (10) @(negedge clk);
    #1;
    chk("no_stale_results", done_f.size(), 0);
    chk("post_reset_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      in_a      = 8'($urandom);
      in_b      = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      in_op     = 2'($urandom);
      res_ready = ($urandom_range(0, 9) < 6);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
